// File: rtl/aes_pkg.sv
// Shared AES definitions: cipher dimensions, state/byte types, FSM encoding,
// GF(2^8) xtime and the forward S-box table used by both cipher and key schedule.
package aes_pkg;

    localparam int NB = 4;
    localparam int NK = 8;
    localparam int NR = 14;

    typedef logic [0:127] state_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_state_e;

    // Byte x of the table sits at bits [8x +: 8].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single forward AES S-box lookup, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX_TABLE[{i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes256_round_engine.sv
// Iterative AES-256 encryptor: one full round per clock, valid/ready on both sides,
// round keys supplied pre-expanded and held stable while busy.
module aes256_round_engine
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 14,
    parameter int NUM_KEYS   = 8
)
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [0:127]                      plaintext,
    input  logic [0:128*(NUM_ROUNDS+1)-1]     expanded_key,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [0:127]                      ciphertext,
    output logic                              busy
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    generate
        if (NUM_ROUNDS != NUM_KEYS + 6) begin : g_bad_cfg
            $error("aes256_round_engine: NUM_ROUNDS must equal NUM_KEYS + 6");
        end
    endgenerate

    fsm_state_e r_fsm;
    fsm_state_e w_fsm_next;
    state_t     r_state;
    state_t     r_ciphertext;
    logic [3:0] r_round;

    state_t     w_sub;
    state_t     w_shift;
    state_t     w_mix;
    state_t     w_round_key;
    state_t     w_round_out;
    logic       w_last_round;

    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%NB)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t o;
        byte_t  a0, a1, a2, a3;
        for (int c = 0; c < NB; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (r_state[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    // The final round omits MixColumns.
    assign w_last_round = (r_round == LAST_ROUND);
    assign w_shift      = shift_rows(w_sub);
    assign w_mix        = mix_columns(w_shift);
    assign w_round_key  = expanded_key[{r_round, 7'b0000000} +: 128];
    assign w_round_out  = (w_last_round ? w_shift : w_mix) ^ w_round_key;
    assign ciphertext   = r_ciphertext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:    if (in_valid)     w_fsm_next = ROUND;
            ROUND:   if (w_last_round) w_fsm_next = DONE;
            DONE:    if (out_ready)    w_fsm_next = IDLE;
            default: w_fsm_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_fsm)
            IDLE:    in_ready = 1'b1;
            ROUND:   busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= '0;
            r_round      <= '0;
            r_ciphertext <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= plaintext ^ expanded_key[0:127];
                        r_round <= 4'd1;
                    end
                end
                ROUND: begin
                    r_state <= w_round_out;
                    if (w_last_round) begin
                        r_ciphertext <= w_round_out;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_round_engine.sv
// Bench for aes256_round_engine: reference AES-256 built from GF(2^8) arithmetic,
// a transaction-timing scoreboard checked every cycle, and directed vectors.
module tb_aes256_round_engine;

    localparam int ROUNDS = 14;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [0:127]       plaintext;
    logic [0:1919]      expanded_key;
    logic               out_valid;
    logic               out_ready;
    logic [0:127]       ciphertext;
    logic               busy;

    aes256_round_engine #(.NUM_ROUNDS(14), .NUM_KEYS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .plaintext    (plaintext),
        .expanded_key (expanded_key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ciphertext   (ciphertext),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [0:1919] key_expand(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rcon;
        logic [0:1919] ek;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int i = 0; i < 60; i++) ek[32*i +: 32] = w[i];
        return ek;
    endfunction

    function automatic logic [0:127] aes_encrypt(input logic [0:127] pt, input logic [0:1919] ek);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [0:127] ct;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[8*(r+4*c) +: 8] ^ ek[8*(r+4*c) +: 8];
        for (int rnd = 1; rnd <= ROUNDS; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_m[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < ROUNDS) begin
                    s[0][c] = gmul(t[0][c],8'h02) ^ gmul(t[1][c],8'h03) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(t[1][c],8'h02) ^ gmul(t[2][c],8'h03) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c],8'h02) ^ gmul(t[3][c],8'h03);
                    s[3][c] = gmul(t[0][c],8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c],8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = s[r][c] ^ ek[128*rnd + 8*(r+4*c) +: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ct[8*(r+4*c) +: 8] = s[r][c];
        return ct;
    endfunction

    // ---------------- transaction-timing scoreboard ----------------
    logic         m_started = 1'b0;
    logic         m_busy    = 1'b0;
    logic         m_present = 1'b0;
    int           m_count   = 0;
    logic [0:127] m_pending = '0;
    logic [0:127] m_ct      = '0;

    always @(posedge clk) begin
        m_started <= 1'b1;
        if (reset) begin
            m_busy    <= 1'b0;
            m_present <= 1'b0;
            m_count   <= 0;
            m_ct      <= '0;
        end else if (!m_busy && in_valid) begin
            m_busy    <= 1'b1;
            m_count   <= 0;
            m_pending <= aes_encrypt(plaintext, expanded_key);
        end else if (m_busy && !m_present) begin
            m_count <= m_count + 1;
            if (m_count == ROUNDS - 1) begin
                m_present <= 1'b1;
                m_ct      <= m_pending;
            end
        end else if (m_present && out_ready) begin
            m_present <= 1'b0;
            m_busy    <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("in_ready", in_ready, !m_busy);
            check("busy", busy, m_busy);
            check("out_valid", out_valid, m_present);
            if (m_present) check("ciphertext", ciphertext, m_ct);
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [0:127] PT_C3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:127] PT_SP  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [0:127] CT_SP  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [0:127] PT_X   = 128'hffeeddccbbaa99887766554433221100;

    task automatic send(input logic [0:127] pt, output int acc_cyc);
        plaintext = pt;
        in_valid  = 1'b1;
        acc_cyc   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) begin
                acc_cyc = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        check("accept_seen", (acc_cyc >= 0), 1'b1);
        $display("accept pt=%h at cycle %0d", pt, acc_cyc);
    endtask

    task automatic wait_out(input int acc_cyc, output logic [0:127] ct, output int lat);
        lat = -1;
        ct  = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc_cyc;
                ct  = ciphertext;
                break;
            end
        end
        $display("result ct=%h latency=%0d", ct, lat);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_release_ov", out_valid, 1'b0);
        check("idle_after_release_ir", in_ready, 1'b1);
    endtask

    initial begin
        int           acc;
        int           lat;
        logic [0:127] ct;
        logic [0:1919] ek;
        logic [0:127] pts [3];
        logic [0:127] exp_ct [3];
        int           acc_b [3];
        int           n_acc;
        int           n_out;
        logic         prev_busy;

        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        plaintext    = '0;
        build_sbox();
        ek           = key_expand(KEY_C3);
        expanded_key = ek;

        // Model pins against published values.
        check("model_sbox_00", sbox_m[8'h00], 8'h63);
        check("model_sbox_53", sbox_m[8'h53], 8'hed);
        check("model_w8", ek[256 +: 32], 32'ha573c29f);
        check("model_c3", aes_encrypt(PT_C3, ek), CT_C3);
        check("model_sp", aes_encrypt(PT_SP, key_expand(KEY_SP)), CT_SP);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ciphertext", ciphertext, 128'h0);

        // FIPS-197 C.3 with latency.
        send(PT_C3, acc);
        wait_out(acc, ct, lat);
        check("c3_ct", ct, CT_C3);
        check("c3_latency", lat, 14);
        release_out();

        // SP800-38A block with a rejected in_valid pulse mid-flight.
        expanded_key = key_expand(KEY_SP);
        send(PT_SP, acc);
        repeat (4) @(negedge clk);
        plaintext = PT_X;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        check("busy_reject_still_busy", busy, 1'b1);
        wait_out(acc, ct, lat);
        check("sp_ct", ct, CT_SP);
        check("sp_latency", lat, 14);

        // Backpressure for 20 cycles with in_valid asserted.
        for (int i = 0; i < 20; i++) begin
            plaintext = PT_C3;
            in_valid  = 1'b1;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_ct", ciphertext, CT_SP);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        release_out();

        // Reset at round 7, asserted together with in_valid.
        expanded_key = key_expand(KEY_C3);
        send(PT_C3, acc);
        repeat (6) @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_ct", ciphertext, 128'h0);
        send(PT_C3, acc);
        wait_out(acc, ct, lat);
        check("post_rst_c3_ct", ct, CT_C3);
        release_out();

        // Back-to-back blocks with in_valid and out_ready held high.
        pts[0] = PT_C3;
        pts[1] = PT_SP;
        pts[2] = PT_X;
        exp_ct[0] = CT_C3;
        exp_ct[1] = aes_encrypt(PT_SP, expanded_key);
        exp_ct[2] = aes_encrypt(PT_X, expanded_key);
        n_acc     = 0;
        n_out     = 0;
        prev_busy = busy;
        out_ready = 1'b1;
        plaintext = pts[0];
        in_valid  = 1'b1;
        for (int i = 0; i < 120 && n_out < 3; i++) begin
            @(negedge clk);
            if (busy && !prev_busy && n_acc < 3) begin
                acc_b[n_acc] = cyc;
                $display("b2b accept %0d at cycle %0d", n_acc, cyc);
                n_acc++;
                if (n_acc < 3) plaintext = pts[n_acc];
                else in_valid = 1'b0;
            end
            if (out_valid && n_out < 3) begin
                $display("b2b result %0d ct=%h", n_out, ciphertext);
                check("b2b_ct", ciphertext, exp_ct[n_out]);
                n_out++;
            end
            prev_busy = busy;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_outputs", n_out, 3);
        check("b2b_accepts", n_acc, 3);
        if (n_acc == 3) begin
            check("b2b_spacing_01", acc_b[1] - acc_b[0], 16);
            check("b2b_spacing_12", acc_b[2] - acc_b[1], 16);
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes256_round_engine.md
Name: aes256_round_engine

Overview:
Iterative AES-256 encryption datapath, directly downstream of the combinational key expansion stage. It consumes the 15 packed round keys that stage produces and encrypts one 128-bit block at a time, performing one full round per clock. Blocks enter and leave through valid/ready handshakes, and the engine sits between the plaintext source and the ciphertext sink.

Parameters:
NUM_ROUNDS, 14, number of cipher rounds; must match the key expansion stage (AES-256 = 14).
NUM_KEYS, 8, key length in 32-bit words; documentation only, not used in the datapath.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  plaintext is valid.
in_ready  output  1  engine can accept a block.
plaintext  input  [0:127]  input block; byte i is bits [8i:8i+7], column-major (byte i = s[i%4][i/4]).
expanded_key  input  [0:128*(NUM_ROUNDS+1)-1]  round key r is bits [128r +: 128]; must stay stable while busy=1.
out_valid  output  1  ciphertext is valid.
out_ready  input  1  the sink accepts the ciphertext.
ciphertext  output  [0:127]  result block, same byte ordering as plaintext.
busy  output  1  high from block acceptance until the ciphertext handshake.

Behaviour:
- FSM states: IDLE, ROUND, DONE. Reset enters IDLE from any state, including mid-block.
- Reset values: in_ready=1 on the first cycle after reset; out_valid=0; busy=0; ciphertext=0; round counter=0; state register=0.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: state <= plaintext ^ rk[0]; round <= 1; go to ROUND.
  - In-flight data is discarded; no partial output is ever presented.
- ROUND
  - Each cycle: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[round]); round++.
  - When round==NUM_ROUNDS, MixColumns is skipped, the result goes to ciphertext, and the FSM moves to DONE.
- DONE
  - out_valid=1; ciphertext is held stable while out_ready=0.
  - On out_ready: out_valid drops and the FSM returns to IDLE on the next edge.
- Latency: if the accept edge is T0, round r completes at edge Tr, and out_valid is high from edge T14.
- Minimum spacing between accepts is 16 cycles. in_ready is low in ROUND and DONE, so there is no overlap.
- in_valid while busy is ignored, with no error flag.
- Round counter is 4 bits and never wraps; values above NUM_ROUNDS are unreachable.
- ShiftRows: row r rotates left by r byte positions.
- MixColumns: standard GF(2^8) matrix [02 03 01 01] and its rotations. xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
- SubBytes: 16 parallel S-box lookups, purely combinational within the cycle.
- out_valid with out_ready held high: exactly one cycle of out_valid.
- Reset asserted in the same cycle as in_valid: reset wins and the block is not accepted.

Decomposition:
- Shared package aes_pkg holds:
  - NB=4, NK=8, NR=14.
  - 128-bit state typedef and 8-bit byte typedef.
  - FSM state enum.
  - xtime function.
  - S-box constant table, shared with the key expansion stage's substitution.
- Sub-module aes_sbox: 8-bit in, 8-bit out, combinational; instantiated 16 times.
- ShiftRows and MixColumns stay inline as functions.

Test Plan:
1. FIPS-197 C.3:
   - Stimulus: key 000102...1e1f expanded, pt 00112233445566778899aabbccddeeff.
   - Required: ct 8ea2b7ca516745bfeafc49904b496089, out_valid rising exactly 14 cycles after the accept edge.
2. SP800-38A:
   - Stimulus: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, pt 6bc1bee22e409f96e93d7e117393172a.
   - Required: ct f3eed1bdb5d2a03c064b5a7e3db181f8.
3. Backpressure: hold out_ready=0 for 20 cycles in DONE.
   - Required: ciphertext and out_valid stable, in_ready=0, no second accept.
   - Then one out_ready pulse: IDLE next cycle.
4. Busy rejection: pulse in_valid with a different plaintext during ROUND.
   - Required: ignored, and the first block's ciphertext is unchanged.
5. Reset mid-block: assert reset at round 7.
   - Required: next cycle out_valid=0, busy=0, in_ready=1.
   - A subsequent C.3 block then yields the correct ciphertext.
6. Back-to-back: 3 blocks with in_valid and out_ready held high.
   - Required: accept edges spaced exactly 16 cycles apart, all ciphertexts correct.
